decode_hazard_unit: RTL and testbench
=====================================

// Module: decode_hazard_unit
// PURPOSE
//  Decode-stage hazard and forwarding controller; feeds the decode-to-execute pipeline register.
//  Keeps a 2-entry shadow scoreboard of the instructions now in EX and MEM.
//  Drives the EXFWD*/MEMFWD* selects, which that register flops to EX with the instruction.
//  Resolves load-use with a 1-cycle bubble (stall + SendNOP) and squashes the decode slot on taken branch/jump.
//  Counts stall cycles.
// PARAMETERS
//  REG_BITS        3   register-specifier width (8 GPRs; R0 is an ordinary register)
//  LOAD_USE_STALL  1   1: bubble on load-use; 0: never stall (EXFWD on load producer, debug only)
//  CNT_W           16  width of stall_count (saturating)
// PORTS
//  clk             in   1         clock
//  rst             in   1         async reset, ACTIVE-LOW (0 = reset)
//  valid_D         in   1         decode slot holds a real instruction (0 after IF/ID flush/NOP)
//  rs_D            in   REG_BITS  source reg 1 of decode instruction
//  rs_used_D       in   1         decode instruction reads rs
//  rt_D            in   REG_BITS  source reg 2 of decode instruction
//  rt_used_D       in   1         decode instruction reads rt
//  write_reg_D     in   REG_BITS  destination reg of decode instruction
//  RegWrt_D        in   1         decode instruction writes a register
//  MemRead_D       in   1         decode instruction is a load
//  halt_D          in   1         decode instruction is HALT
//  branchtake_E    in   1         EX resolved taken branch/jump this cycle
//  stall_F         out  1         hold PC and IF/ID this cycle
//  flush_D         out  1         clear IF/ID at next edge (wrong-path fetch)
//  SendNOP_D       out  1         inject bubble into decode-to-execute register this cycle
//  EXFWD1_D/EXFWD2_D    out 1     rs/rt forwarded from EX/MEM result (producer 1 ahead)
//  MEMFWD1_D/MEMFWD2_D  out 1     rs/rt forwarded from MEM/WB result (producer 2 ahead)
//  halted          out  1         sticky: HALT has entered EX; fetch frozen
//  stall_count     out  CNT_W     load-use stall cycles since reset, saturating
// BEHAVIOUR
//  Shadow entry = {v, wr[REG_BITS-1:0], we, ld}; slots EXs (now in EX) and MEMs (now in MEM).
//  Reset (rst=0, async): EXs, MEMs, halted and stall_count clear; all outputs 0.
//  Every posedge (no reset): MEMs <= EXs.
//    EXs <= bubble (v=0) if SendNOP_D, else {valid_D, write_reg_D, RegWrt_D, MemRead_D}.
//  hit1_EX  = rs_used_D & valid_D & EXs.v  & EXs.we  & (EXs.wr==rs_D).
//  hit1_MEM = rs_used_D & valid_D & MEMs.v & MEMs.we & (MEMs.wr==rs_D). rt likewise (hit2_*).
//  load_use = LOAD_USE_STALL & EXs.ld & (hit1_EX | hit2_EX).
//  Combinational outputs (same cycle, no latency):
//   flush_D   = branchtake_E.
//   stall_F   = (load_use & ~branchtake_E) | halted.
//   SendNOP_D = load_use | branchtake_E | halted.
//   EXFWD1_D  = hit1_EX & ~SendNOP_D.
//   MEMFWD1_D = hit1_MEM & ~hit1_EX & ~SendNOP_D. Youngest producer wins; never both set.
//   EXFWD2_D/MEMFWD2_D: same rules using hit2_*.
//  Load-use sequence (exactly 1 bubble):
//   cycle 0: stall + bubble;
//   cycle 1: producer now in MEMs, consumer re-evaluates, gets MEMFWD.
//  Flush beats stall: taken branch + load-use in same cycle -> SendNOP_D=1, stall_F=0, flush_D=1, no count.
//  halted sets at the edge where a valid, unsquashed halt_D enters EXs.
//   halt_D with SendNOP_D=1 is squashed, so halted does not set.
//   Once set: stall_F=1, SendNOP_D=1 until reset; older instructions still drain.
//  stall_count += 1 on each edge where load_use & ~branchtake_E & ~halted; holds at 2^CNT_W-1.
//  Reset asserted mid-operation clears scoreboard immediately; no forward/stall outputs until new entries arrive.
// TESTING
//  1 Reset: rst=0 with random inputs -> all outputs 0; release, valid_D=0 for 3 cycles -> outputs stay 0.
//  2 Back-to-back ALU: wr R3, then rs_D=R3 -> EXFWD1_D=1.
//    One instr later, rt_D=R3 -> MEMFWD2_D=1, EXFWD2_D=0.
//  3 Load-use: LD R2, then rs_D=R2 -> stall_F=1, SendNOP_D=1 for exactly 1 cycle.
//    Next cycle MEMFWD1_D=1; stall_count=1.
//  4 Double producer: R5 written in EXs and MEMs, rs_D=rt_D=R5 -> EXFWD1_D=EXFWD2_D=1, MEMFWD*=0.
//  5 Flush vs stall: load-use + branchtake_E=1 same cycle -> flush_D=1, SendNOP_D=1, stall_F=0, count unchanged.
//  6 HALT: valid halt_D enters EX -> halted=1, stall_F=1 held 10+ cycles.
//    Assert rst=0 mid-hold -> halted=0 asynchronously.

Source files
------------

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard/forwarding controller: shadows the EX and MEM instructions,
// selects forwarding, inserts load-use bubbles, squashes on taken branch, freezes on HALT.
module decode_hazard_unit #(
    parameter int REG_BITS       = 3,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_D,
    input  logic [REG_BITS-1:0] rs_D,
    input  logic                rs_used_D,
    input  logic [REG_BITS-1:0] rt_D,
    input  logic                rt_used_D,
    input  logic [REG_BITS-1:0] write_reg_D,
    input  logic                RegWrt_D,
    input  logic                MemRead_D,
    input  logic                halt_D,
    input  logic                branchtake_E,
    output logic                stall_F,
    output logic                flush_D,
    output logic                SendNOP_D,
    output logic                EXFWD1_D,
    output logic                EXFWD2_D,
    output logic                MEMFWD1_D,
    output logic                MEMFWD2_D,
    output logic                halted,
    output logic [CNT_W-1:0]    stall_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    localparam logic LU_EN = (LOAD_USE_STALL != 0);

    logic                vld_p1, ex_we_p1, ex_ld_p1;
    logic [REG_BITS-1:0] ex_wr_p1;
    logic                vld_p2, mem_we_p2;
    logic [REG_BITS-1:0] mem_wr_p2;

    logic hit1_ex, hit2_ex, hit1_mem, hit2_mem;
    logic load_use, send_nop;

    always_comb begin
        hit1_ex  = rs_used_D & valid_D & vld_p1 & ex_we_p1  & (ex_wr_p1  == rs_D);
        hit2_ex  = rt_used_D & valid_D & vld_p1 & ex_we_p1  & (ex_wr_p1  == rt_D);
        hit1_mem = rs_used_D & valid_D & vld_p2 & mem_we_p2 & (mem_wr_p2 == rs_D);
        hit2_mem = rt_used_D & valid_D & vld_p2 & mem_we_p2 & (mem_wr_p2 == rt_D);
        load_use = LU_EN & ex_ld_p1 & (hit1_ex | hit2_ex);
        send_nop = load_use | branchtake_E | halted;
    end

    // Outputs are forced low while reset is held, including the pass-through flush.
    always_comb begin
        flush_D   = rst & branchtake_E;
        stall_F   = rst & ((load_use & ~branchtake_E) | halted);
        SendNOP_D = rst & send_nop;
        EXFWD1_D  = rst & hit1_ex & ~send_nop;
        EXFWD2_D  = rst & hit2_ex & ~send_nop;
        MEMFWD1_D = rst & hit1_mem & ~hit1_ex & ~send_nop;
        MEMFWD2_D = rst & hit2_mem & ~hit2_ex & ~send_nop;
    end

    // Stage boundary: decode -> EX slot (p1) -> MEM slot (p2)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            ex_we_p1    <= 1'b0;
            ex_ld_p1    <= 1'b0;
            vld_p2      <= 1'b0;
            mem_we_p2   <= 1'b0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            vld_p1    <= valid_D & ~send_nop;
            ex_we_p1  <= RegWrt_D;
            ex_ld_p1  <= MemRead_D & ~send_nop;
            vld_p2    <= vld_p1;
            mem_we_p2 <= ex_we_p1;
            halted    <= halted | (valid_D & halt_D & ~send_nop);
            if (load_use & ~branchtake_E & ~halted)
                stall_count <= sat_inc(stall_count);
        end
    end

    always_ff @(posedge clk) begin
        ex_wr_p1  <= write_reg_D;
        mem_wr_p2 <= ex_wr_p1;
    end

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed self-checking bench for decode_hazard_unit: reset, forwarding,
// load-use bubble, flush-over-stall and HALT freeze.
module tb_decode_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_D, rs_used_D, rt_used_D, RegWrt_D, MemRead_D, halt_D, branchtake_E;
    logic [2:0]  rs_D, rt_D, write_reg_D;
    logic        stall_F, flush_D, SendNOP_D, EXFWD1_D, EXFWD2_D, MEMFWD1_D, MEMFWD2_D, halted;
    logic [15:0] stall_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decode_hazard_unit #(.REG_BITS(3), .LOAD_USE_STALL(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_D(valid_D), .rs_D(rs_D), .rs_used_D(rs_used_D),
        .rt_D(rt_D), .rt_used_D(rt_used_D), .write_reg_D(write_reg_D), .RegWrt_D(RegWrt_D),
        .MemRead_D(MemRead_D), .halt_D(halt_D), .branchtake_E(branchtake_E),
        .stall_F(stall_F), .flush_D(flush_D), .SendNOP_D(SendNOP_D),
        .EXFWD1_D(EXFWD1_D), .EXFWD2_D(EXFWD2_D), .MEMFWD1_D(MEMFWD1_D), .MEMFWD2_D(MEMFWD2_D),
        .halted(halted), .stall_count(stall_count)
    );

    task automatic set_in(input logic v, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu, input logic [2:0] wr,
                          input logic we, input logic ld, input logic hlt, input logic br);
        valid_D = v; rs_D = rs; rs_used_D = rsu; rt_D = rt; rt_used_D = rtu;
        write_reg_D = wr; RegWrt_D = we; MemRead_D = ld; halt_D = hlt; branchtake_E = br;
    endtask

    task automatic idle();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic advance();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 3'($urandom), 1'b1, 3'($urandom), 1'b1, 3'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            @(negedge clk);
            outs = {stall_F, flush_D, SendNOP_D, EXFWD1_D, EXFWD2_D, MEMFWD1_D, MEMFWD2_D};
            total++;
            if (outs !== 7'b0 || halted !== 1'b0 || stall_count !== 16'd0)
                $display("FAIL reset_hold[%0d]: outs=%b halted=%b cnt=%0d, want all 0", i, outs, halted, stall_count);
            else passed++;
        end
        idle();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            @(negedge clk);
            outs = {stall_F, flush_D, SendNOP_D, EXFWD1_D, EXFWD2_D, MEMFWD1_D, MEMFWD2_D};
            total++;
            if (outs !== 7'b0 || halted !== 1'b0)
                $display("FAIL reset_idle[%0d]: outs=%b halted=%b, want 0", i, outs, halted);
            else passed++;
        end
        advance();
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        set_in(1'b1, 3'd3, 1'b1, 3'd1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if ({EXFWD1_D, MEMFWD1_D, stall_F} !== 3'b100)
            $display("FAIL alu_exfwd: EXFWD1=%b MEMFWD1=%b stall=%b, want 1 0 0", EXFWD1_D, MEMFWD1_D, stall_F);
        else passed++;
        advance();
        set_in(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if ({MEMFWD2_D, EXFWD2_D, EXFWD1_D} !== 3'b100)
            $display("FAIL alu_memfwd: MEMFWD2=%b EXFWD2=%b EXFWD1=%b, want 1 0 0", MEMFWD2_D, EXFWD2_D, EXFWD1_D);
        else passed++;
        advance();
        idle(); advance(); advance();
    endtask

    task automatic test_load_use();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        set_in(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if ({stall_F, SendNOP_D, EXFWD1_D, MEMFWD1_D} !== 4'b1100)
            $display("FAIL lu_stall: stall=%b nop=%b EXFWD1=%b MEMFWD1=%b, want 1 1 0 0", stall_F, SendNOP_D, EXFWD1_D, MEMFWD1_D);
        else passed++;
        advance();
        @(negedge clk);
        total++;
        if ({stall_F, SendNOP_D, MEMFWD1_D, EXFWD1_D} !== 4'b0010)
            $display("FAIL lu_resume: stall=%b nop=%b MEMFWD1=%b EXFWD1=%b, want 0 0 1 0", stall_F, SendNOP_D, MEMFWD1_D, EXFWD1_D);
        else passed++;
        total++;
        if (stall_count !== 16'd1)
            $display("FAIL lu_count: stall_count=%0d, want 1", stall_count);
        else passed++;
        advance();
        idle(); advance(); advance();
    endtask

    task automatic test_double_producer();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        advance(); advance();
        set_in(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if ({EXFWD1_D, EXFWD2_D, MEMFWD1_D, MEMFWD2_D} !== 4'b1100)
            $display("FAIL double_prod: EX1=%b EX2=%b MEM1=%b MEM2=%b, want 1 1 0 0", EXFWD1_D, EXFWD2_D, MEMFWD1_D, MEMFWD2_D);
        else passed++;
        advance();
        idle(); advance(); advance();
    endtask

    task automatic test_flush_vs_stall();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        set_in(1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total++;
        if ({flush_D, SendNOP_D, stall_F, EXFWD2_D} !== 4'b1100)
            $display("FAIL flush_stall: flush=%b nop=%b stall=%b EXFWD2=%b, want 1 1 0 0", flush_D, SendNOP_D, stall_F, EXFWD2_D);
        else passed++;
        advance();
        idle();
        @(negedge clk);
        total++;
        if (stall_count !== 16'd1)
            $display("FAIL flush_count: stall_count=%0d, want 1", stall_count);
        else passed++;
        advance(); advance();
    endtask

    task automatic test_halt();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        advance();
        idle();
        @(negedge clk);
        total++;
        if (halted !== 1'b0)
            $display("FAIL halt_squashed: halted=%b, want 0", halted);
        else passed++;
        advance();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (halted !== 1'b0 || stall_F !== 1'b0)
            $display("FAIL halt_pre: halted=%b stall=%b, want 0 0", halted, stall_F);
        else passed++;
        advance();
        idle();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if ({halted, stall_F, SendNOP_D} !== 3'b111)
                $display("FAIL halt_hold[%0d]: halted=%b stall=%b nop=%b, want 1 1 1", i, halted, stall_F, SendNOP_D);
            else passed++;
            advance();
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({halted, stall_F, SendNOP_D} !== 3'b000 || stall_count !== 16'd0)
            $display("FAIL halt_async_rst: halted=%b stall=%b nop=%b cnt=%0d, want 0 0 0 0", halted, stall_F, SendNOP_D, stall_count);
        else passed++;
        @(negedge clk); rst = 1'b1;
        advance();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_double_producer();
        test_flush_vs_stall();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
